// File: rtl/f8_test_supervisor.sv
// rtl/f8_test_supervisor.sv - run supervisor for f8 benches and bring-up boards
// Stretches power-on reset, then watches traps, pass requests and a timeout.
module f8_test_supervisor #(
  parameter int NUM_TRAPS      = 2,
  parameter int RESET_CYCLES   = 5,
  parameter int TIMEOUT_CYCLES = 2045,
  parameter int HOLDOFF_CYCLES = 5,
  parameter int CNT_W          = 32,
  localparam int TID_W         = (NUM_TRAPS > 1) ? $clog2(NUM_TRAPS) : 1
) (
  input  logic                 clk,
  input  logic                 power_on_reset,
  input  logic [NUM_TRAPS-1:0] trap,
  input  logic                 pass_req,
  input  logic                 restart,
  output logic                 system_reset,
  output logic                 running,
  output logic                 done,
  output logic                 pass,
  output logic                 fail_trap,
  output logic                 fail_timeout,
  output logic [TID_W-1:0]     trap_id,
  output logic [CNT_W-1:0]     cycle_count
);

  typedef enum logic [1:0] {
    S_RESET_HOLD = 2'd0,
    S_RUN        = 2'd1,
    S_HOLDOFF    = 2'd2,
    S_DONE       = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [31:0]          cnt_q, cnt_d;
  logic [CNT_W-1:0]     cycle_count_q, cycle_count_d;
  logic [NUM_TRAPS-1:0] trap_prev_q;
  logic [TID_W-1:0]     trap_id_q, trap_id_d;
  logic                 system_reset_q, system_reset_d;
  logic                 running_q, running_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic                 fail_trap_q, fail_trap_d;
  logic                 fail_timeout_q, fail_timeout_d;
  logic [NUM_TRAPS-1:0] edges;
  logic [TID_W-1:0]     first_id;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    cycle_count_d  = cycle_count_q;
    trap_id_d      = trap_id_q;
    system_reset_d = system_reset_q;
    running_d      = running_q;
    done_d         = done_q;
    pass_d         = pass_q;
    fail_trap_d    = fail_trap_q;
    fail_timeout_d = fail_timeout_q;

    // A line already high when RUN begins has trap_prev set, so it never counts.
    edges    = trap & ~trap_prev_q;
    first_id = '0;
    for (int i = NUM_TRAPS - 1; i >= 0; i--) begin
      if (edges[i]) first_id = TID_W'(i);
    end

    case (state_q)
      S_RESET_HOLD: begin
        if (cnt_q == 32'(RESET_CYCLES - 1)) begin
          state_d        = S_RUN;
          cnt_d          = '0;
          system_reset_d = 1'b0;
          running_d      = 1'b1;
          cycle_count_d  = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_RUN: begin
        if (|edges) begin
          state_d   = S_HOLDOFF;
          trap_id_d = first_id;
          cnt_d     = '0;
        end else if (pass_req) begin
          state_d   = S_DONE;
          running_d = 1'b0;
          done_d    = 1'b1;
          pass_d    = 1'b1;
        end else if (cycle_count_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d        = S_DONE;
          running_d      = 1'b0;
          done_d         = 1'b1;
          fail_timeout_d = 1'b1;
        end else if (cycle_count_q != '1) begin
          cycle_count_d = cycle_count_q + 1'b1;
        end
      end
      S_HOLDOFF: begin
        if (cnt_q >= 32'(HOLDOFF_CYCLES)) begin
          state_d     = S_DONE;
          running_d   = 1'b0;
          done_d      = 1'b1;
          fail_trap_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_DONE: begin
        if (restart) begin
          state_d        = S_RESET_HOLD;
          cnt_d          = '0;
          system_reset_d = 1'b1;
          done_d         = 1'b0;
          pass_d         = 1'b0;
          fail_trap_d    = 1'b0;
          fail_timeout_d = 1'b0;
          trap_id_d      = '0;
          cycle_count_d  = '0;
        end
      end
      default: state_d = S_RESET_HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (power_on_reset) begin
      state_q        <= S_RESET_HOLD;
      cnt_q          <= '0;
      cycle_count_q  <= '0;
      trap_prev_q    <= '0;
      trap_id_q      <= '0;
      system_reset_q <= 1'b1;
      running_q      <= 1'b0;
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
      fail_trap_q    <= 1'b0;
      fail_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      cycle_count_q  <= cycle_count_d;
      trap_prev_q    <= trap;
      trap_id_q      <= trap_id_d;
      system_reset_q <= system_reset_d;
      running_q      <= running_d;
      done_q         <= done_d;
      pass_q         <= pass_d;
      fail_trap_q    <= fail_trap_d;
      fail_timeout_q <= fail_timeout_d;
    end
  end

  assign system_reset = system_reset_q;
  assign running      = running_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign fail_trap    = fail_trap_q;
  assign fail_timeout = fail_timeout_q;
  assign trap_id      = trap_id_q;
  assign cycle_count  = cycle_count_q;

endmodule

// File: tb/tb_f8_test_supervisor.sv
// tb/tb_f8_test_supervisor.sv - directed and random runs of f8_test_supervisor
// Verdicts and their timing are predicted from event times, not from FSM steps.
module tb_f8_test_supervisor;

  localparam int NT      = 2;
  localparam int RST_C   = 5;
  localparam int TMO_C   = 2045;
  localparam int HOLD_C  = 5;
  localparam int NEVER   = 1 << 30;

  logic          clk = 1'b0;
  logic          power_on_reset = 1'b1;
  logic [NT-1:0] trap = '0;
  logic          pass_req = 1'b0;
  logic          restart = 1'b0;
  logic          system_reset, running, done, pass, fail_trap, fail_timeout;
  logic [0:0]    trap_id;
  logic [31:0]   cycle_count;

  int total = 0;
  int bad   = 0;

  f8_test_supervisor #(
    .NUM_TRAPS(NT), .RESET_CYCLES(RST_C), .TIMEOUT_CYCLES(TMO_C),
    .HOLDOFF_CYCLES(HOLD_C), .CNT_W(32)
  ) dut (
    .clk(clk), .power_on_reset(power_on_reset), .trap(trap), .pass_req(pass_req),
    .restart(restart), .system_reset(system_reset), .running(running), .done(done),
    .pass(pass), .fail_trap(fail_trap), .fail_timeout(fail_timeout),
    .trap_id(trap_id), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!power_on_reset) begin
      total++;
      assert (!(system_reset && running)) else begin
        bad++;
        $error("FAIL invariant: observed=%0d expected=%0d", {system_reset, running}, 2'b00);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, ".sysrst"}, system_reset, 1);
    check({tag, ".running"}, running, 0);
    check({tag, ".done"}, done, 0);
    check({tag, ".flags"}, {pass, fail_trap, fail_timeout}, 0);
    check({tag, ".trap_id"}, trap_id, 0);
    check({tag, ".count"}, cycle_count, 0);
  endtask

  task automatic wait_run(input string tag);
    int n = 0;
    while (!running && n < 100) begin
      tick();
      n++;
    end
    check({tag, ".reset_len"}, n, RST_C);
    check({tag, ".sysrst_low"}, system_reset, 0);
  endtask

  task automatic do_restart(input string tag);
    trap = '0;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check_cleared(tag);
    wait_run(tag);
  endtask

  // Caller guarantees the DUT has just entered RUN with cycle_count=0.
  task automatic run_scenario(input string tag, input int tc, input logic [NT-1:0] mask,
                              input int pc, input bit hold_rs);
    int et, ep, ev, exp_ticks, k;
    int exp_kind;
    int exp_id;
    et = (tc >= 0 && tc < TMO_C) ? tc : NEVER;
    ep = (pc >= 0 && pc < TMO_C) ? pc : NEVER;
    exp_id = mask[0] ? 0 : 1;
    if (et != NEVER && et <= ep) begin
      exp_kind = 1; ev = et; exp_ticks = et + 1 + HOLD_C + 1;
    end else if (ep != NEVER) begin
      exp_kind = 0; ev = ep; exp_ticks = ep + 1; exp_id = 0;
    end else begin
      exp_kind = 2; ev = TMO_C - 1; exp_ticks = TMO_C; exp_id = 0;
    end

    k = 0;
    while (!done && k < TMO_C + 100) begin
      if (k == tc) trap = trap | mask;
      pass_req = (k == pc);
      restart = hold_rs;
      tick();
      k++;
    end
    pass_req = 1'b0;
    restart = 1'b0;

    check({tag, ".latency"}, k, exp_ticks);
    check({tag, ".done"}, done, 1);
    check({tag, ".running"}, running, 0);
    check({tag, ".pass"}, pass, exp_kind == 0);
    check({tag, ".fail_trap"}, fail_trap, exp_kind == 1);
    check({tag, ".fail_timeout"}, fail_timeout, exp_kind == 2);
    check({tag, ".trap_id"}, trap_id, exp_id);
    check({tag, ".count"}, cycle_count, ev);

    pass_req = 1'b1;
    trap = '0;
    tick();
    trap = '1;
    tick();
    pass_req = 1'b0;
    check({tag, ".sticky_flags"}, {done, pass, fail_trap, fail_timeout},
          {1'b1, exp_kind == 0, exp_kind == 1, exp_kind == 2});
    check({tag, ".sticky_count"}, cycle_count, ev);
  endtask

  initial begin
    power_on_reset = 1'b1;
    repeat (3) tick();
    check_cleared("por");
    power_on_reset = 1'b0;
    wait_run("por");

    run_scenario("timeout", -1, 2'b00, -1, 1'b0);
    do_restart("restart1");

    run_scenario("trap1_at100", 100, 2'b10, -1, 1'b1);
    do_restart("restart2");

    run_scenario("trap11_pass", 50, 2'b11, 50, 1'b0);
    do_restart("restart3");

    run_scenario("pass_at_timeout", -1, 2'b00, TMO_C - 1, 1'b0);

    trap = 2'b01;
    power_on_reset = 1'b1;
    repeat (2) tick();
    power_on_reset = 1'b0;
    wait_run("held_trap");
    run_scenario("held_trap", -1, 2'b00, 10, 1'b0);
    do_restart("restart4");

    for (int r = 0; r < 6; r++) begin
      int tc, pc;
      logic [NT-1:0] m;
      tc = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 2100));
      pc = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 2100));
      m  = NT'($urandom_range(1, 3));
      run_scenario($sformatf("rand%0d", r), tc, m, pc, 1'b0);
      do_restart($sformatf("rand%0d_rs", r));
    end

    for (int k = 0; k < 30; k++) tick();
    trap = 2'b01;
    tick();
    repeat (3) tick();
    check("mid_holdoff.running", running, 1);
    check("mid_holdoff.count", cycle_count, 30);
    check("mid_holdoff.done", done, 0);
    power_on_reset = 1'b1;
    tick();
    check_cleared("por_holdoff");
    power_on_reset = 1'b0;
    trap = '0;
    wait_run("por_holdoff");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
